alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Execution-side consumer of the 4-bit ALUOp code produced by the ALU control decoder; performs the operation on the datapath operands.
- Single-cycle ops return a registered result one cycle after Start.
- Mul/Div run iteratively (shift-add / restoring) over DATA_WIDTH cycles and write the HI/LO registers.
- Mfhi reads HI. Sits between the register-file read stage and the writeback mux; the control FSM stalls on Busy.

Parameters:
- DATA_WIDTH, 32, operand/result width; Mul/Div iteration count.
- CNT_W, 5, width of the iteration counter (log2 DATA_WIDTH).

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle request; samples ALUOp, A, B, Shamt.
- ALUOp  in  4  operation code (AluOp_* constants).
- A  in  DATA_WIDTH  operand rs.
- B  in  DATA_WIDTH  operand rt/immediate.
- Shamt  in  5  shift amount for Sll.
- Result  out  DATA_WIDTH  registered result, held until next completion.
- Zero  out  1  registered (Result == 0).
- Busy  out  1  high while a Mul/Div is in progress.
- Done  out  1  one-cycle pulse when Result is valid.
- Hi  out  DATA_WIDTH  HI register.
- Lo  out  DATA_WIDTH  LO register.

Behaviour:
- Interface rule: one clock Clk; Reset_n is asynchronous, active-low.
- Reset (any time, including mid-Mul/Div): state IDLE, Result=0, Zero=1, Busy=0, Done=0, Hi=0, Lo=0, counter=0. Partial operation discarded.
- States:
  - IDLE.
  - RUN (iterating, counter DATA_WIDTH-1 down to 0).
  - FIX (sign correction, HI/LO write).
- IDLE with Start and a single-cycle op: at the next edge Result/Zero are updated and Done=1 for one cycle; remain IDLE. Latency 1.
  - AluOp_Add: A+B mod 2^32, no overflow trap.
  - AluOp_Sub: A-B mod 2^32.
  - AluOp_Or: A|B.
  - AluOp_Sll: B<<Shamt; zero fill; Shamt=0 passes B.
  - AluOp_Slt: signed A<B gives 1, else 0.
  - AluOp_Lui: {B[15:0],16'h0}.
  - AluOp_Mfhi: Result=Hi.
  - Any undefined code: treated as Add.
- IDLE with Start and AluOp_Mul or AluOp_Div:
  - Latch |A|, |B| and the sign flags; Busy=1; go to RUN.
  - RUN lasts exactly DATA_WIDTH cycles, one bit per cycle.
  - Then FIX for one cycle. At the FIX exit edge: Hi, Lo, Result=Lo and Zero are written; Done=1; Busy=0; return to IDLE.
  - Done rises DATA_WIDTH+1 edges after the Start edge (33 for the default).
- Mul: signed 32x32→64; Hi=upper word, Lo=lower word. Magnitude product, negated when the sign flags differ.
- Div: signed, truncating toward zero. Lo=quotient, Hi=remainder; remainder takes the sign of the dividend.
- Div by zero: Lo=32'hFFFF_FFFF, Hi=A. Still takes the full latency, no exception.
- Div of 32'h8000_0000 by -1: Lo=32'h8000_0000, Hi=0.
- Start while Busy: ignored; no state change and no extra Done.
- Start in the same cycle Done pulses: accepted; it is a new operation.
- Mfhi issued while Busy: ignored, because Start is ignored while Busy. The control FSM must wait for Done.
- Hi/Lo change only on Mul/Div completion or reset. Result/Zero change only on Done or reset.

Decomposition:
- AluOp_* codes stay in the shared ALU_Parameters.v include; no new codes are added.
- Local constants for the state encoding (IDLE/RUN/FIX) live in the same include, under an ALU-state section.
- One sub-module is natural: alu_muldiv_iter. It holds the shift-add/restoring datapath, counter and sign fix, behind start/op/done signals.
- Single-cycle ops remain inline in alu_multicycle.

Test Plan:
- Reset mid-op: Start Mul A=5 B=7, pull Reset_n low at cycle 10 → Busy=0, Hi=Lo=0, Result=0, Zero=1 immediately. No Done after release.
- Single-cycle ops:
  - Add 32'hFFFF_FFFF+1 → Result=0, Zero=1, Done at +1 cycle.
  - Slt A=-1 B=1 → 1.
  - Sll B=1 Shamt=31 → 32'h8000_0000.
  - Lui B=16'h1234 → 32'h1234_0000.
- Mul A=-3 B=7:
  - Busy for 33 cycles; Done at edge 33.
  - Hi=32'hFFFF_FFFF, Lo=32'hFFFF_FFEB, Result=Lo.
  - A follow-up Mfhi returns 32'hFFFF_FFFF after 1 cycle.
- Div:
  - A=-7 B=2 → Lo=32'hFFFF_FFFD, Hi=32'hFFFF_FFFF.
  - A=9 B=0 → Lo=32'hFFFF_FFFF, Hi=9.
  - A=32'h8000_0000 B=-1 → Lo=32'h8000_0000, Hi=0.
- Handshake:
  - Start re-pulsed with Add during Busy → ignored; Result is unchanged until the Mul Done.
  - Start asserted in the Done cycle → accepted; a second Done appears 1 cycle later.
- Random regression: 1000 random A/B across all ops, checked against a signed reference model. Exactly one Done per accepted Start.

Source files
------------

// File: rtl/alu_multicycle_pkg.sv
// Shared ALU constants: the 4-bit ALUOp codes from the ALU control decoder
// and the state encoding of the iterative Mul/Div engine.
package alu_multicycle_pkg;

    localparam logic [3:0] ALUOP_ADD  = 4'h0;
    localparam logic [3:0] ALUOP_SUB  = 4'h1;
    localparam logic [3:0] ALUOP_OR   = 4'h2;
    localparam logic [3:0] ALUOP_SLL  = 4'h3;
    localparam logic [3:0] ALUOP_SLT  = 4'h4;
    localparam logic [3:0] ALUOP_LUI  = 4'h5;
    localparam logic [3:0] ALUOP_MFHI = 4'h6;
    localparam logic [3:0] ALUOP_MUL  = 4'h7;
    localparam logic [3:0] ALUOP_DIV  = 4'h8;

    // ALU-state section: Mul/Div engine sequencing.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALUOP_MUL) || (op == ALUOP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative signed multiply (shift-add) and divide (restoring) on operand
// magnitudes, one bit per cycle, with a final sign-correction cycle.
module alu_muldiv_iter
    import alu_multicycle_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] hi_q;     // mul: upper product, div: partial remainder
    logic [DATA_WIDTH-1:0] lo_q;     // mul: multiplier/lower product, div: dividend/quotient
    logic [DATA_WIDTH-1:0] opnd_q;   // mul: multiplicand, div: divisor (magnitudes)
    logic                  div_q;
    logic                  neg_q;    // result sign (operand signs differ)
    logic                  neg_r;    // remainder sign follows the dividend
    logic                  dvz_q;

    logic [DATA_WIDTH-1:0]   mag_a, mag_b;
    logic [DATA_WIDTH:0]     mul_sum, div_shift, div_diff;
    logic                    div_ge;
    logic [2*DATA_WIDTH-1:0] prod, prod_fix;

    assign mag_a = a[DATA_WIDTH-1] ? -a : a;
    assign mag_b = b[DATA_WIDTH-1] ? -b : b;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    assign prod     = {hi_q, lo_q};
    assign prod_fix = neg_q ? -prod : prod;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIX);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        hi = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
        lo = prod_fix[DATA_WIDTH-1:0];
        if (div_q) begin
            hi = neg_r ? -hi_q : hi_q;
            lo = dvz_q ? '1 : (neg_q ? -lo_q : lo_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dvz_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        cnt    <= CNT_W'(DATA_WIDTH - 1);
                        hi_q   <= '0;
                        lo_q   <= op_div ? mag_a : mag_b;
                        opnd_q <= op_div ? mag_b : mag_a;
                        div_q  <= op_div;
                        neg_q  <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
                        neg_r  <= a[DATA_WIDTH-1];
                        dvz_q  <= (b == '0);
                    end
                end
                ST_RUN: begin
                    if (div_q) begin
                        hi_q <= div_ge ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
                        lo_q <= {lo_q[DATA_WIDTH-2:0], div_ge};
                    end else begin
                        hi_q <= mul_sum[DATA_WIDTH:1];
                        lo_q <= {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
                    end
                    if (cnt == '0) state <= ST_FIX;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                ST_FIX:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execution ALU: single-cycle ops complete one edge after Start; Mul/Div are
// delegated to the iterative engine and update HI/LO on completion.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [3:0]            ALUOp,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [4:0]            Shamt,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Zero,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo
);

    logic                  accept, md_start, single_fire, md_done;
    logic [DATA_WIDTH-1:0] md_hi, md_lo, single_res;

    // Start is dropped entirely while a Mul/Div is in flight.
    assign accept      = Start && !Busy;
    assign md_start    = accept && is_muldiv(ALUOp);
    assign single_fire = accept && !is_muldiv(ALUOp);

    alu_muldiv_iter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_muldiv (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .start  (md_start),
        .op_div (ALUOp == ALUOP_DIV),
        .a      (A),
        .b      (B),
        .busy   (Busy),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    always_comb begin
        single_res = A + B;
        case (ALUOp)
            ALUOP_SUB:  single_res = A - B;
            ALUOP_OR:   single_res = A | B;
            ALUOP_SLL:  single_res = B << Shamt;
            ALUOP_SLT: begin
                single_res    = '0;
                single_res[0] = $signed(A) < $signed(B);
            end
            ALUOP_LUI:  single_res = DATA_WIDTH'(B[15:0]) << 16;
            ALUOP_MFHI: single_res = Hi;
            default:    single_res = A + B;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Result <= '0;
            Zero   <= 1'b1;
            Done   <= 1'b0;
            Hi     <= '0;
            Lo     <= '0;
        end else begin
            Done <= single_fire || md_done;
            if (md_done) begin
                Hi     <= md_hi;
                Lo     <= md_lo;
                Result <= md_lo;
                Zero   <= (md_lo == '0);
            end else if (single_fire) begin
                Result <= single_res;
                Zero   <= (single_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench: directed literal cases plus randomized ops against a
// behavioural model that schedules each answer at its architectural latency.
module tb_alu_multicycle;
    import alu_multicycle_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  ALUOp = 4'h0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [4:0]  Shamt = '0;
    logic [31:0] Result, Hi, Lo;
    logic        Zero, Busy, Done;

    alu_multicycle #(.DATA_WIDTH(32), .CNT_W(5)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ALUOp(ALUOp),
        .A(A), .B(B), .Shamt(Shamt), .Result(Result), .Zero(Zero),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] m_result = '0, m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_zero = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0;
    int          n_accepted = 0;
    int          dut_dones = 0;

    function automatic logic [31:0] single_ref(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [4:0] sh,
                                               input logic [31:0] hi);
        case (op)
            ALUOP_SUB:  return a - b;
            ALUOP_OR:   return a | b;
            ALUOP_SLL:  return b << sh;
            ALUOP_SLT:  return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
            ALUOP_LUI:  return {b[15:0], 16'h0000};
            ALUOP_MFHI: return hi;
            default:    return a + b;
        endcase
    endfunction

    function automatic void md_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
        longint p;
        int     qa, qb;
        if (op == ALUOP_MUL) begin
            p = longint'(signed'(a)) * longint'(signed'(b));
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'h0) begin
            l = 32'hFFFF_FFFF;
            h = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000;
            h = 32'h0;
        end else begin
            qa = a;
            qb = b;
            l  = qa / qb;
            h  = qa % qb;
        end
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        bit acc;
        if (!Reset_n) begin
            m_result = '0; m_zero = 1'b1; m_busy = 1'b0; m_done = 1'b0;
            m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            acc    = Start && (m_left == 0);
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_result = p_lo;
                    m_zero = (p_lo == 32'h0); m_done = 1'b1; m_busy = 1'b0;
                end
            end
            if (acc) begin
                n_accepted++;
                if (ALUOp == ALUOP_MUL || ALUOp == ALUOP_DIV) begin
                    md_ref(ALUOp, A, B, p_hi, p_lo);
                    m_left = 33;
                    m_busy = 1'b1;
                end else begin
                    m_result = single_ref(ALUOp, A, B, Shamt, m_hi);
                    m_zero   = (m_result == 32'h0);
                    m_done   = 1'b1;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset_n && Done) dut_dones++;
        if (cmp_en && Reset_n) begin
            check("done",   32'(Done), 32'(m_done));
            check("busy",   32'(Busy), 32'(m_busy));
            check("result", Result,    m_result);
            check("zero",   32'(Zero), 32'(m_zero));
            check("hi",     Hi,        m_hi);
            check("lo",     Lo,        m_lo);
        end
    end

    // Caller sits at a negedge; Start is sampled at the following posedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        ALUOp = op; A = a; B = b; Shamt = sh; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (Done !== 1'b1 && n < 60) begin
            @(negedge Clk);
            n++;
        end
        if (Done !== 1'b1) check("done_timeout", 32'(Done), 32'd1);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d, base_acc, base_done;
        logic [3:0] op;

        repeat (3) @(negedge Clk);
        check("rst_result", Result, 32'h0);
        check("rst_zero",   32'(Zero), 32'd1);
        check("rst_busy",   32'(Busy), 32'd0);
        check("rst_done",   32'(Done), 32'd0);
        check("rst_hi",     Hi, 32'h0);
        check("rst_lo",     Lo, 32'h0);
        Reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge Clk);

        issue(ALUOP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0);
        wait_done(n);
        check("add_latency", 32'(n), 32'd0);
        check("add_result",  Result, 32'h0);
        check("add_zero",    32'(Zero), 32'd1);

        issue(ALUOP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0);
        wait_done(n);
        check("slt_result", Result, 32'h1);

        issue(ALUOP_SLL, 32'h0, 32'h1, 5'd31);
        wait_done(n);
        check("sll_result", Result, 32'h8000_0000);

        issue(ALUOP_LUI, 32'h0, 32'hABCD_1234, 5'd0);
        wait_done(n);
        check("lui_result", Result, 32'h1234_0000);

        issue(ALUOP_MUL, 32'hFFFF_FFFD, 32'd7, 5'd0);
        check("mul_busy", 32'(Busy), 32'd1);
        wait_done(n);
        check("mul_latency", 32'(n), 32'd33);
        check("mul_hi",      Hi, 32'hFFFF_FFFF);
        check("mul_lo",      Lo, 32'hFFFF_FFEB);
        check("mul_result",  Result, 32'hFFFF_FFEB);

        issue(ALUOP_MFHI, 32'h0, 32'h0, 5'd0);
        wait_done(n);
        check("mfhi_latency", 32'(n), 32'd0);
        check("mfhi_result",  Result, 32'hFFFF_FFFF);

        issue(ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
        wait_done(n);
        check("div_neg_lo", Lo, 32'hFFFF_FFFD);
        check("div_neg_hi", Hi, 32'hFFFF_FFFF);

        issue(ALUOP_DIV, 32'd9, 32'd0, 5'd0);
        wait_done(n);
        check("div0_latency", 32'(n), 32'd33);
        check("div0_lo",      Lo, 32'hFFFF_FFFF);
        check("div0_hi",      Hi, 32'd9);

        issue(ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        wait_done(n);
        check("divovf_lo", Lo, 32'h8000_0000);
        check("divovf_hi", Hi, 32'h0);

        issue(ALUOP_MUL, 32'd5, 32'd7, 5'd0);
        repeat (3) @(negedge Clk);
        issue(ALUOP_ADD, 32'd1, 32'd2, 5'd0);
        check("busy_start_done",   32'(Done), 32'd0);
        check("busy_start_result", Result, 32'h8000_0000);
        wait_done(n);
        check("mul57_result", Result, 32'd35);
        issue(ALUOP_ADD, 32'd100, 32'd23, 5'd0);
        check("b2b_done",   32'(Done), 32'd1);
        check("b2b_result", Result, 32'd123);

        issue(ALUOP_MUL, 32'd5, 32'd7, 5'd0);
        repeat (9) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("rstmid_busy",   32'(Busy), 32'd0);
        check("rstmid_done",   32'(Done), 32'd0);
        check("rstmid_hi",     Hi, 32'h0);
        check("rstmid_lo",     Lo, 32'h0);
        check("rstmid_result", Result, 32'h0);
        check("rstmid_zero",   32'(Zero), 32'd1);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        d = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) d++;
        end
        check("rstmid_no_done", 32'(d), 32'd0);

        base_acc  = n_accepted;
        base_done = dut_dones;
        for (int i = 0; i < 1000; i++) begin
            op = 4'($urandom_range(0, 15));
            issue(op, rnd_operand(), rnd_operand(), 5'($urandom));
            if ((op == ALUOP_MUL || op == ALUOP_DIV) && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 20)) @(negedge Clk);
                issue(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), 5'($urandom));
            end
            wait_done(n);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
        end
        repeat (5) @(negedge Clk);
        check("done_per_start", 32'(dut_dones - base_done), 32'(n_accepted - base_acc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
